// File: rtl/axi_cache_pkg.sv
// Shared definitions for the 2-way cache and its DRAM line server.
// Keeps line geometry and FSM encoding in one place.
package axi_cache_pkg;

    localparam int AXI_ADDR_W   = 32;
    localparam int AXI_DATA_W   = 8;
    localparam int AXI_OFFSET_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LAT   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_WDATA = 2'd3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dram_rom.sv
// Synchronous-read line storage; contents fixed at elaboration.
// Word i holds the low bits of i.
module dram_rom
    import axi_cache_pkg::*;
#(
    parameter int    MEM_ADDR_WIDTH = 12,
    parameter int    DATA_WIDTH     = AXI_DATA_W,
    parameter string INIT_FILE      = ""
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en_i,
    input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0]     data_o
);

    logic [DATA_WIDTH-1:0] word;

    assign word = DATA_WIDTH'(addr_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_o <= '0;
        end else if (en_i) begin
            data_o <= word;
        end
    end

endmodule

// File: rtl/dram_line_server.sv
// Read-only DRAM model: one AR returns an aligned line burst.
// Writes are handshaken and dropped; drops are counted.
module dram_line_server
    import axi_cache_pkg::*;
#(
    parameter int    ADDR_WIDTH     = AXI_ADDR_W,
    parameter int    DATA_WIDTH     = AXI_DATA_W,
    parameter int    OFFSET_WIDTH   = AXI_OFFSET_W,
    parameter int    MEM_ADDR_WIDTH = 12,
    parameter int    READ_LATENCY   = 4,
    parameter string INIT_FILE      = ""
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_axi_ARVALID,
    output logic                  s_axi_ARREADY,
    input  logic [ADDR_WIDTH-1:0] s_axi_ARADDR,
    output logic                  s_axi_RVALID,
    input  logic                  s_axi_RREADY,
    output logic [DATA_WIDTH-1:0] s_axi_RDATA,
    input  logic                  s_axi_AWVALID,
    output logic                  s_axi_AWREADY,
    input  logic [ADDR_WIDTH-1:0] s_axi_AWADDR,
    input  logic                  s_axi_WVALID,
    output logic                  s_axi_WREADY,
    input  logic [DATA_WIDTH-1:0] s_axi_WDATA,
    output logic [7:0]            write_drop_cnt
);

    localparam int BEATS = 1 << OFFSET_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT =
        OFFSET_WIDTH'(BEATS - 1);
    localparam logic [15:0] LAT_INIT = 16'(READ_LATENCY);

    logic [1:0]                state_q, state_d;
    logic [15:0]               lat_q, lat_d;
    logic [OFFSET_WIDTH-1:0]   beat_q, beat_d;
    logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [MEM_ADDR_WIDTH-1:0] rom_addr;
    logic                      rvalid_q, rvalid_d;
    logic                      wready_q, wready_d;
    logic [7:0]                drop_q, drop_d;
    logic                      idle;
    logic                      unused_in;

    assign idle = (state_q == ST_IDLE);

    assign s_axi_ARREADY  = reset_n & idle;
    assign s_axi_AWREADY  = reset_n & idle & ~s_axi_ARVALID;
    assign s_axi_RVALID   = rvalid_q;
    assign s_axi_WREADY   = wready_q;
    assign write_drop_cnt = drop_q;

    assign unused_in = ^{s_axi_AWADDR, s_axi_WDATA, s_axi_ARADDR};

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        beat_d   = beat_q;
        base_d   = base_q;
        rvalid_d = rvalid_q;
        wready_d = 1'b0;
        drop_d   = drop_q;
        unique case (state_q)
            ST_IDLE: begin
                if (s_axi_ARVALID) begin
                    base_d = {s_axi_ARADDR[MEM_ADDR_WIDTH-1:OFFSET_WIDTH],
                              {OFFSET_WIDTH{1'b0}}};
                    beat_d = '0;
                    lat_d  = LAT_INIT;
                    state_d = (READ_LATENCY == 0) ? ST_BURST : ST_LAT;
                end else if (s_axi_AWVALID) begin
                    state_d  = ST_WDATA;
                    wready_d = 1'b1;
                end
            end
            ST_LAT: begin
                if (lat_q <= 16'd1) begin
                    state_d = ST_BURST;
                end else begin
                    lat_d = lat_q - 16'd1;
                end
            end
            ST_BURST: begin
                // First BURST cycle primes the ROM; RVALID follows it.
                if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                end else if (s_axi_RREADY) begin
                    if (beat_q == LAST_BEAT) begin
                        rvalid_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        beat_d = beat_q + OFFSET_WIDTH'(1);
                    end
                end
            end
            ST_WDATA: begin
                if (s_axi_WVALID && wready_q) begin
                    drop_d  = sat_inc8(drop_q);
                    state_d = ST_IDLE;
                end else begin
                    wready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address runs one beat ahead so RDATA lands with RVALID.
    assign rom_addr = base_q + MEM_ADDR_WIDTH'(beat_d);

    dram_rom #(
        .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .INIT_FILE     (INIT_FILE)
    ) u_rom (
        .clk    (clk),
        .reset_n(reset_n),
        .en_i   (state_q == ST_BURST),
        .addr_i (rom_addr),
        .data_o (s_axi_RDATA)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            lat_q    <= '0;
            beat_q   <= '0;
            base_q   <= '0;
            rvalid_q <= 1'b0;
            wready_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            beat_q   <= beat_d;
            base_q   <= base_d;
            rvalid_q <= rvalid_d;
            wready_q <= wready_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_dram_line_server.sv
// Bench: latency-4 and latency-0 servers driven in lockstep,
// checked every cycle against a transaction-level model.
module tb_dram_line_server;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arvalid, rready, awvalid, wvalid;
    logic [31:0] araddr, awaddr;
    logic [7:0]  wdata;
    logic [1:0]  arready, rvalid, awready, wready;
    logic [7:0]  rdata [2];
    logic [7:0]  drop [2];

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;

    bit m_rd [2];
    bit m_wr [2];
    int m_since [2];
    int m_beats [2];
    int m_base [2];
    int m_drop [2];
    int ar_cyc [2];
    int rv_cyc [2];
    bit rv_seen [2];
    bit prev_rv [2];
    int prev_rd [2];
    int got0 [$];
    int got1 [$];

    always #5 clk = ~clk;

    dram_line_server u_d4 (
        .clk(clk), .reset_n(rst_n),
        .s_axi_ARVALID(arvalid), .s_axi_ARREADY(arready[0]),
        .s_axi_ARADDR(araddr),
        .s_axi_RVALID(rvalid[0]), .s_axi_RREADY(rready),
        .s_axi_RDATA(rdata[0]),
        .s_axi_AWVALID(awvalid), .s_axi_AWREADY(awready[0]),
        .s_axi_AWADDR(awaddr),
        .s_axi_WVALID(wvalid), .s_axi_WREADY(wready[0]),
        .s_axi_WDATA(wdata),
        .write_drop_cnt(drop[0])
    );

    dram_line_server #(.READ_LATENCY(0)) u_d0 (
        .clk(clk), .reset_n(rst_n),
        .s_axi_ARVALID(arvalid), .s_axi_ARREADY(arready[1]),
        .s_axi_ARADDR(araddr),
        .s_axi_RVALID(rvalid[1]), .s_axi_RREADY(rready),
        .s_axi_RDATA(rdata[1]),
        .s_axi_AWVALID(awvalid), .s_axi_AWREADY(awready[1]),
        .s_axi_AWADDR(awaddr),
        .s_axi_WVALID(wvalid), .s_axi_WREADY(wready[1]),
        .s_axi_WDATA(wdata),
        .write_drop_cnt(drop[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        vectors++;
        errs++;
        $display("FAIL %s: cycle budget expired", nm);
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    function automatic bit exp_rv(input int i);
        return m_rd[i] && (m_since[i] >= 1 + lat_of(i));
    endfunction

    function automatic int exp_rd(input int i);
        return ((m_base[i] + m_beats[i]) % 4096) % 256;
    endfunction

    function automatic bit m_idle(input int i);
        return !m_rd[i] && !m_wr[i];
    endfunction

    // Model step on each edge, then compare 1 time unit later.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst_n && prev_rv[i] && rready) begin
                if (i == 0) got0.push_back(prev_rd[i]);
                else        got1.push_back(prev_rd[i]);
            end
            if (!rst_n) begin
                m_rd[i]   = 0;
                m_wr[i]   = 0;
                m_drop[i] = 0;
            end else if (m_rd[i]) begin
                if (exp_rv(i) && rready) begin
                    m_beats[i]++;
                    if (m_beats[i] == 16) m_rd[i] = 0;
                end
                m_since[i]++;
            end else if (m_wr[i]) begin
                if (wvalid) begin
                    if (m_drop[i] < 255) m_drop[i]++;
                    m_wr[i] = 0;
                end
            end else if (arvalid) begin
                m_rd[i]    = 1;
                m_since[i] = 0;
                m_beats[i] = 0;
                m_base[i]  = int'(araddr[11:4]) * 16;
                ar_cyc[i]  = cyc;
                rv_seen[i] = 0;
                if (i == 0) got0.delete();
                else        got1.delete();
            end else if (awvalid) begin
                m_wr[i] = 1;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("arready%0d", i), int'(arready[i]),
                int'(rst_n && m_idle(i)));
            chk($sformatf("awready%0d", i), int'(awready[i]),
                int'(rst_n && m_idle(i) && !arvalid));
            chk($sformatf("rvalid%0d", i), int'(rvalid[i]),
                int'(exp_rv(i)));
            if (exp_rv(i))
                chk($sformatf("rdata%0d", i), int'(rdata[i]), exp_rd(i));
            chk($sformatf("wready%0d", i), int'(wready[i]),
                int'(m_wr[i]));
            chk($sformatf("drop%0d", i), int'(drop[i]), m_drop[i]);
            if (rvalid[i] && !rv_seen[i] && m_rd[i]) begin
                rv_seen[i] = 1;
                rv_cyc[i]  = cyc;
            end
            prev_rv[i] = rvalid[i];
            prev_rd[i] = int'(rdata[i]);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(m_idle(0) && m_idle(1)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeout("wait_idle");
    endtask

    // mode 0: RREADY high, 1: RREADY late, 2: random stalls
    task automatic do_read(input logic [31:0] a, input int mode);
        int n = 0;
        wait_idle();
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = a;
        rready  = (mode == 0);
        @(negedge clk);
        arvalid = 1'b0;
        while ((m_rd[0] || m_rd[1]) && n < 400) begin
            if (mode == 0) rready = 1'b1;
            else if (mode == 1) rready = (n >= 2);
            else rready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (n >= 400) timeout("do_read");
        rready = 1'b1;
    endtask

    task automatic chk_line(input string nm, input int q[$],
                            input int first);
        chk({nm, "_len"}, q.size(), 16);
        for (int k = 0; k < q.size() && k < 16; k++)
            chk($sformatf("%s_b%0d", nm, k), q[k], (first + k) % 256);
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        arvalid = 1'b0;
        araddr  = '0;
        rready  = 1'b0;
        awvalid = 1'b0;
        awaddr  = '0;
        wvalid  = 1'b0;
        wdata   = '0;
        repeat (3) @(negedge clk);
        chk("rst_rvalid", int'(rvalid[0]), 0);
        chk("rst_rdata", int'(rdata[0]), 0);
        chk("rst_wready", int'(wready[0]), 0);
        chk("rst_arready", int'(arready[0]), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_arready", int'(arready[0]), 1);

        do_read(32'h0000_0123, 0);
        chk("lat4_first", rv_cyc[0] - ar_cyc[0], 5);
        chk("lat0_first", rv_cyc[1] - ar_cyc[1], 1);
        chk_line("full4", got0, 32'h20);
        chk_line("full0", got1, 32'h20);
        chk("arready_after", int'(arready[0]), 1);

        do_read(32'h0000_0123, 1);
        chk_line("late0", got1, 32'h20);
        chk_line("late4", got0, 32'h20);

        repeat (3) begin
            do_read(32'h0000_0123, 2);
            chk_line("stall4", got0, 32'h20);
            chk_line("stall0", got1, 32'h20);
        end

        wait_idle();
        @(negedge clk);
        arvalid = 1'b1;
        awvalid = 1'b1;
        araddr  = 32'h0000_0047;
        awaddr  = 32'h0000_0040;
        rready  = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!(m_wr[0] && m_wr[1]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeout("aw_accept");
        chk_line("arwin4", got0, 32'h40);
        awvalid = 1'b0;
        wvalid  = 1'b1;
        wdata   = 8'hA5;
        wait_idle();
        wvalid = 1'b0;
        chk("drop4", int'(drop[0]), 1);
        chk("drop0", int'(drop[1]), 1);
        do_read(32'h0000_0040, 0);
        chk_line("reread", got0, 32'h40);

        do_read(32'h0000_FFF8, 0);
        chk_line("wrap4", got0, 32'hF0);
        chk_line("wrap0", got1, 32'hF0);

        wait_idle();
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = 32'h0000_0123;
        rready  = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (m_beats[0] != 7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("beat7");
        rst_n = 1'b0;
        #1;
        chk("mid_rvalid", int'(rvalid[0]), 0);
        chk("mid_arready", int'(arready[0]), 0);
        repeat (2) begin
            @(negedge clk);
            chk("hold_rvalid", int'(rvalid[0]), 0);
        end
        rst_n = 1'b1;
        #1;
        chk("post_arready", int'(arready[0]), 1);
        chk("post_rvalid", int'(rvalid[0]), 0);
        do_read(32'h0000_0123, 0);
        chk_line("post4", got0, 32'h20);

        for (int t = 0; t < 8; t++) begin
            logic [31:0] a;
            int exp_first;
            a = $urandom;
            exp_first = int'(a[11:4]) * 16 % 256;
            do_read(a, int'($urandom_range(0, 2)));
            chk_line("rnd4", got0, exp_first);
            chk_line("rnd0", got1, exp_first);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end

endmodule
